// File: rtl/dspl_pkg.sv
// ============================================================================
// Module      : dspl_pkg
// Description : Shared glyph codes, message ids, FSM encodings and digit-word
//               helper for the 8-digit display message sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dspl_pkg;

  localparam int DIG_W = 6;
  typedef logic [DIG_W-1:0] dig_t;

  localparam logic [3:0] GL_0 = 4'h0;
  localparam logic [3:0] GL_1 = 4'h1;
  localparam logic [3:0] GL_2 = 4'h2;
  localparam logic [3:0] GL_3 = 4'h3;
  localparam logic [3:0] GL_4 = 4'h4;
  localparam logic [3:0] GL_5 = 4'h5;
  localparam logic [3:0] GL_6 = 4'h6;
  localparam logic [3:0] GL_7 = 4'h7;
  localparam logic [3:0] GL_8 = 4'h8;
  localparam logic [3:0] GL_9 = 4'h9;
  localparam logic [3:0] GL_P = 4'hA;
  localparam logic [3:0] GL_B = 4'hB;
  localparam logic [3:0] GL_C = 4'hC;
  localparam logic [3:0] GL_R = 4'hD;
  localparam logic [3:0] GL_E = 4'hE;
  localparam logic [3:0] GL_S = 4'hF;

  localparam logic [2:0] MSG_BLANK  = 3'd0;
  localparam logic [2:0] MSG_NUM    = 3'd1;
  localparam logic [2:0] MSG_SCORE  = 3'd2;
  localparam logic [2:0] MSG_ERROR  = 3'd3;
  localparam logic [2:0] MSG_PLAYER = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic [13:0] VALUE_MAX  = 14'd9999;
  localparam logic [3:0]  CONV_STEPS = 4'd14;

  function automatic dig_t mk_dig(input logic en, input logic [3:0] glyph, input logic dp);
    return {en, glyph, dp};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 14-bit binary to 4-digit BCD (double-dabble, one
//               shift per clock). Result is held until the next start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import dspl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic [13:0] sh_bin;
  logic [15:0] sh_bcd;
  logic [15:0] adj;
  logic [3:0]  cnt;

  always_comb begin
    adj = sh_bcd;
    for (int k = 0; k < 4; k++) begin
      if (sh_bcd[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = sh_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_bin <= '0;
      sh_bcd <= '0;
      cnt    <= '0;
    end else if (start) begin
      sh_bin <= bin;
      sh_bcd <= '0;
      cnt    <= CONV_STEPS;
    end else if (cnt != 4'd0) begin
      {sh_bcd, sh_bin} <= {adj, sh_bin} << 1;
      cnt              <= cnt - 4'd1;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done = (cnt == 4'd1);
  assign bcd  = sh_bcd;

endmodule

`default_nettype wire

// File: rtl/dspl_msg_seq.sv
// ============================================================================
// Module      : dspl_msg_seq
// Description : Message sequencer for the 8-digit display: accepts a message
//               request, converts the value to BCD, loads d1..d8 atomically.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dspl_msg_seq
  import dspl_pkg::*;
#(
  parameter int BLINK_HALF_COUNT = 25_000_000
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_msg,
  input  logic [13:0]      req_value,
  input  logic             req_blink,
  output logic [DIG_W-1:0] d1,
  output logic [DIG_W-1:0] d2,
  output logic [DIG_W-1:0] d3,
  output logic [DIG_W-1:0] d4,
  output logic [DIG_W-1:0] d5,
  output logic [DIG_W-1:0] d6,
  output logic [DIG_W-1:0] d7,
  output logic [DIG_W-1:0] d8
);

  localparam int CNT_W = (BLINK_HALF_COUNT > 1) ? $clog2(BLINK_HALF_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_COUNT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             start;
  logic             load;
  logic             conv_done;
  logic [15:0]      bcd;
  logic [13:0]      sat_value;
  logic [2:0]       msg_q;
  logic             blink_pend;
  logic             blink_act;
  logic             visible;
  logic [CNT_W-1:0] bcnt;
  dig_t             dig_q [8];
  dig_t             words [8];
  dig_t             shown [8];

  assign sat_value = (req_value > VALUE_MAX) ? VALUE_MAX : req_value;

  bin2bcd_seq u_conv (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (sat_value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_CONV;
      ST_CONV: if (conv_done) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    start     = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        start     = req_valid;
      end
      ST_LOAD: load = 1'b1;
      default: ;
    endcase
  end

  // Blink bit is staged so the currently shown message keeps its own blink mode until LOAD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msg_q      <= MSG_BLANK;
      blink_pend <= 1'b0;
    end else if (start) begin
      msg_q      <= req_msg;
      blink_pend <= req_blink;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) words[i] = '0;
    case (msg_q)
      MSG_NUM: begin
        words[3] = mk_dig(bcd[15:12] != 4'd0, bcd[15:12], 1'b0);
        words[2] = mk_dig(bcd[15:8]  != 8'd0, bcd[11:8],  1'b0);
        words[1] = mk_dig(bcd[15:4]  != 12'd0, bcd[7:4],  1'b0);
        words[0] = mk_dig(1'b1, bcd[3:0], 1'b0);
      end
      MSG_SCORE: begin
        words[7] = mk_dig(1'b1, GL_S, 1'b0);
        words[6] = mk_dig(1'b1, GL_C, 1'b0);
        words[3] = mk_dig(1'b1, bcd[15:12], 1'b0);
        words[2] = mk_dig(1'b1, bcd[11:8],  1'b0);
        words[1] = mk_dig(1'b1, bcd[7:4],   1'b0);
        words[0] = mk_dig(1'b1, bcd[3:0],   1'b0);
      end
      MSG_ERROR: begin
        words[7] = mk_dig(1'b1, GL_E, 1'b0);
        words[6] = mk_dig(1'b1, GL_R, 1'b0);
        words[5] = mk_dig(1'b1, GL_R, 1'b0);
        words[0] = mk_dig(1'b1, bcd[3:0], 1'b0);
      end
      MSG_PLAYER: begin
        words[7] = mk_dig(1'b1, GL_P, 1'b0);
        words[0] = mk_dig(1'b1, bcd[3:0], 1'b0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) dig_q[i] <= '0;
      blink_act <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < 8; i++) dig_q[i] <= words[i];
      blink_act <= blink_pend;
    end
  end

  // LOAD restarts the blink period in the visible phase, overriding any toggle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcnt    <= '0;
      visible <= 1'b1;
    end else if (load) begin
      bcnt    <= '0;
      visible <= 1'b1;
    end else if (blink_act) begin
      if (bcnt == CNT_LAST) begin
        bcnt    <= '0;
        visible <= ~visible;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_mask
    assign shown[g] = {dig_q[g][DIG_W-1] & visible, dig_q[g][DIG_W-2:0]};
  end

  assign d1 = shown[0];
  assign d2 = shown[1];
  assign d3 = shown[2];
  assign d4 = shown[3];
  assign d5 = shown[4];
  assign d6 = shown[5];
  assign d7 = shown[6];
  assign d8 = shown[7];

endmodule

`default_nettype wire

// File: tb/tb_dspl_msg_seq.sv
// ============================================================================
// Module      : tb_dspl_msg_seq
// Description : Self-checking bench for dspl_msg_seq (timeline model + literals).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dspl_msg_seq;

  localparam int BH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_msg = 3'd0;
  logic [13:0] req_value = 14'd0;
  logic        req_blink = 1'b0;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;

  int total = 0;
  int bad   = 0;

  dspl_msg_seq #(.BLINK_HALF_COUNT(BH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_msg   (req_msg),
    .req_value (req_value),
    .req_blink (req_blink),
    .d1 (d1), .d2 (d2), .d3 (d3), .d4 (d4),
    .d5 (d5), .d6 (d6), .d7 (d7), .d8 (d8)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word shown at position pos (1 = rightmost) for a message, from the display rules.
  function automatic logic [5:0] exp_word(input int msg, input int v, input int pos);
    int s, p, dig;
    s = (v > 9999) ? 9999 : v;
    if (pos <= 4) begin
      p   = 10 ** (pos - 1);
      dig = (s / p) % 10;
    end else begin
      p   = 1;
      dig = 0;
    end
    exp_word = 6'b0;
    case (msg)
      1: if (pos <= 4 && (pos == 1 || s >= p)) exp_word = {1'b1, 4'(dig), 1'b0};
      2: begin
        if (pos == 8) exp_word = {1'b1, 4'hF, 1'b0};
        if (pos == 7) exp_word = {1'b1, 4'hC, 1'b0};
        if (pos <= 4) exp_word = {1'b1, 4'(dig), 1'b0};
      end
      3: begin
        if (pos == 8) exp_word = {1'b1, 4'hE, 1'b0};
        if (pos == 7 || pos == 6) exp_word = {1'b1, 4'hD, 1'b0};
        if (pos == 1) exp_word = {1'b1, 4'(dig), 1'b0};
      end
      4: begin
        if (pos == 8) exp_word = {1'b1, 4'hA, 1'b0};
        if (pos == 1) exp_word = {1'b1, 4'(dig), 1'b0};
      end
      default: ;
    endcase
  endfunction

  // Timeline model: a request accepted at edge T is displayed from edge T+15.
  int         m_cyc = 0, m_acc = 0, m_load = 0, m_msg = 0, m_val = 0;
  bit         m_busy = 0, m_blink = 0, m_pblink = 0;
  logic [5:0] m_w [8];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy  = 0;
      m_blink = 0;
      for (int i = 0; i < 8; i++) m_w[i] = 6'b0;
    end else begin
      m_cyc++;
      if (m_busy && m_cyc == m_acc + 15) begin
        for (int i = 0; i < 8; i++) m_w[i] = exp_word(m_msg, m_val, i + 1);
        m_blink = m_pblink;
        m_load  = m_cyc;
        m_busy  = 0;
      end else if (!m_busy && req_valid) begin
        m_busy   = 1;
        m_acc    = m_cyc;
        m_msg    = int'(req_msg);
        m_val    = int'(req_value);
        m_pblink = req_blink;
      end
    end
  end

  always @(negedge clock) begin
    logic [47:0] e;
    bit vis;
    vis = !m_blink || ((((m_cyc - m_load) / BH) % 2) == 0);
    e = '0;
    for (int i = 7; i >= 0; i--) e = {e[41:0], (vis ? m_w[i][5] : 1'b0), m_w[i][4:0]};
    check("model_dwords", {d8, d7, d6, d5, d4, d3, d2, d1}, e);
    check("model_ready", req_ready, !m_busy);
  end

  task automatic send(input logic [2:0] m, input int v, input logic b, output int busy_len);
    int guard;
    @(negedge clock);
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    req_valid = 1'b1;
    req_msg   = m;
    req_value = 14'(v);
    req_blink = b;
    @(negedge clock);
    req_valid = 1'b0;
    busy_len = 0;
    guard    = 0;
    while (!req_ready && guard < 40) begin
      busy_len++;
      @(negedge clock);
      guard++;
    end
  endtask

  initial begin
    int bl, accepts, guard;
    logic [15:0] pat;

    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_d", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'h0);
    check("reset_ready", req_ready, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_reset_d", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'h0);

    send(3'd1, 42, 1'b0, bl);
    check("num42_busy_len", bl, 15);
    check("num42_d1", d1, 6'b100100);
    check("num42_d2", d2, 6'b101000);
    check("num42_d8_d3", {d8, d7, d6, d5, d4, d3}, 36'h0);

    send(3'd2, 7, 1'b0, bl);
    check("score7_busy_len", bl, 15);
    check("score7_d8", d8, 6'b111110);
    check("score7_d7", d7, 6'b111000);
    check("score7_d6_d5", {d6, d5}, 12'h0);
    check("score7_d4_d1", {d4, d3, d2, d1}, {6'b100000, 6'b100000, 6'b100000, 6'b101110});

    send(3'd1, 12345, 1'b0, bl);
    check("num_sat_d4_d1", {d4, d3, d2, d1}, {4{6'b110010}});

    send(3'd3, 3, 1'b0, bl);
    check("err3_d8_d6", {d8, d7, d6}, {6'b111100, 6'b111010, 6'b111010});
    check("err3_d5_d2", {d5, d4, d3, d2}, 24'h0);
    check("err3_d1", d1, 6'b100110);

    send(3'd1, 1005, 1'b0, bl);
    check("num1005_d4_d1", {d4, d3, d2, d1}, {6'b100010, 6'b100000, 6'b100000, 6'b101010});
    send(3'd1, 0, 1'b0, bl);
    check("num0_d", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'h20);
    send(3'd6, 88, 1'b0, bl);
    check("msg6_blank", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'h0);
    send(3'd2, 9999, 1'b0, bl);

    // Held request: one acceptance per IDLE visit.
    @(negedge clock);
    req_valid = 1'b1;
    req_msg   = 3'd1;
    req_value = 14'd77;
    req_blink = 1'b0;
    accepts   = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) accepts++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    check("held_accepts", accepts, 2);
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    check("held_drain", req_ready, 1'b1);

    send(3'd4, 2, 1'b1, bl);
    check("player_busy_len", bl, 15);
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      pat = {pat[14:0], d8[5]};
      if (i == 5) check("blink_dark_glyph", {d8, d1}, {6'b010100, 6'b000100});
      @(negedge clock);
    end
    check("blink_pattern", pat, 16'hF0F0);

    @(negedge clock);
    req_valid = 1'b1;
    req_msg   = 3'd2;
    req_value = 14'd5;
    req_blink = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midconv_reset_d", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'h0);
    check("midconv_reset_ready", req_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("after_drop_d", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
